// File: rtl/vend_pkg.sv
// Shared definitions for the vending front end and the vending FSM:
// coin FSM states, default width thresholds and coin value encoding.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    JAM  = 2'd2
  } coin_state_e;

  // Coin value as seen by the vending FSM: i alone = single, i with j = double.
  typedef enum logic [1:0] {
    COIN_NONE   = 2'd0,
    COIN_SINGLE = 2'd1,
    COIN_DOUBLE = 2'd2,
    COIN_REJECT = 2'd3
  } coin_class_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DEB_CYCLES_DEF  = 16;
  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned SMALL_MIN_DEF   = 8;
  localparam int unsigned SMALL_MAX_DEF   = 31;
  localparam int unsigned LARGE_MIN_DEF   = 32;
  localparam int unsigned LARGE_MAX_DEF   = 63;

  // Classify a completed sensor pulse of w cycles; a coin outside both
  // windows, or any coin while crediting is disabled, is returned.
  function automatic coin_class_e classify_width(
    input int unsigned w,
    input int unsigned small_min,
    input int unsigned small_max,
    input int unsigned large_min,
    input int unsigned large_max,
    input logic        accept
  );
    coin_class_e c;
    c = COIN_REJECT;
    if (w >= small_min && w <= small_max) begin
      c = accept ? COIN_SINGLE : COIN_REJECT;
    end else if (w >= large_min && w <= large_max) begin
      c = accept ? COIN_DOUBLE : COIN_REJECT;
    end
    return c;
  endfunction

endpackage

// File: rtl/coin_front_end_if.sv
// Bundle of the raw sensor/button inputs and the strobes handed to the vending FSM.
interface coin_front_end_if;
  logic coin_sns;
  logic btn_raw;
  logic accept_en;
  logic i;
  logic j;
  logic pu;
  logic reject;
  logic jam;

  modport master (
    output coin_sns, btn_raw, accept_en,
    input  i, j, pu, reject, jam
  );

  modport slave (
    input  coin_sns, btn_raw, accept_en,
    output i, j, pu, reject, jam
  );
endinterface

// File: rtl/coin_front_end_sync_debounce.sv
// Multi-flop synchroniser followed by an optional stability filter.
// With DEB_CYCLES = 0 the block is a plain synchroniser.
module sync_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (DEB_CYCLES == 0) begin : g_no_deb
    assign dout = synced;
  end else begin : g_deb
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [DEB_W-1:0] deb_cnt;
    logic             deb_q;

    // Count consecutive samples that disagree with the filtered level;
    // flip the level once DEB_CYCLES of them have been seen in a row.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        deb_cnt <= '0;
        deb_q   <= 1'b0;
      end else if (synced == deb_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_cnt <= '0;
        deb_q   <= synced;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end

    assign dout = deb_q;
  end

endmodule

// File: rtl/coin_front_end.sv
// Input conditioning ahead of the vending FSM: synchronises the coin sensor,
// debounces the purchase button, classifies coins by pulse width and issues
// single-cycle i/j/pu/reject strobes plus a jam level.
module coin_front_end
  import vend_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SMALL_MIN   = SMALL_MIN_DEF,
  parameter int unsigned SMALL_MAX   = SMALL_MAX_DEF,
  parameter int unsigned LARGE_MIN   = LARGE_MIN_DEF,
  parameter int unsigned LARGE_MAX   = LARGE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  coin_front_end_if.slave   bus
);

  logic s;
  logic btn_deb;
  logic btn_deb_q;
  logic pu_evt;

  coin_state_e          state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CNT_W-1:0]     cnt_sat;
  coin_class_e          cls;

  logic i_q, j_q, pu_q, reject_q;
  logic i_n, j_n, pu_n, reject_n;
  logic pend, pend_n;
  logic pend_j, pend_j_n;
  logic credit, dbl;

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (0)
  ) u_coin_sync (
    .clk (clk),
    .rst (rst),
    .din (bus.coin_sns),
    .dout(s)
  );

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_deb (
    .clk (clk),
    .rst (rst),
    .din (bus.btn_raw),
    .dout(btn_deb)
  );

  assign cnt_sat = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign pu_evt  = btn_deb & ~btn_deb_q;

  // Coin FSM state and pulse-width counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Coin FSM next state, counter update and classification result.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cls     = COIN_NONE;
    case (state)
      IDLE: begin
        if (s) begin
          state_n = MEAS;
          cnt_n   = CNT_W'(1);
        end
      end
      MEAS: begin
        if (s) begin
          cnt_n = cnt_sat;
          if (32'(cnt_sat) > LARGE_MAX) begin
            state_n = JAM;
          end
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
          cls     = classify_width(32'(cnt), SMALL_MIN, SMALL_MAX,
                                   LARGE_MIN, LARGE_MAX, bus.accept_en);
        end
      end
      JAM: begin
        if (s) begin
          cnt_n = cnt_sat;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
          cls     = COIN_REJECT;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Strobe arbitration: a credit that lands on a pu cycle waits one cycle in
  // the pending slot; rejects are never deferred.
  always_comb begin
    credit   = (cls == COIN_SINGLE) || (cls == COIN_DOUBLE);
    dbl      = (cls == COIN_DOUBLE);
    i_n      = 1'b0;
    j_n      = 1'b0;
    pu_n     = pu_evt;
    reject_n = (cls == COIN_REJECT);
    pend_n   = pend;
    pend_j_n = pend_j;
    if (pend && !pu_evt) begin
      i_n    = 1'b1;
      j_n    = pend_j;
      pend_n = 1'b0;
    end
    if (credit) begin
      if (pu_evt) begin
        pend_n   = 1'b1;
        pend_j_n = dbl;
      end else begin
        i_n = 1'b1;
        j_n = dbl;
      end
    end
  end

  // Registered strobes, pending slot and button edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q       <= 1'b0;
      j_q       <= 1'b0;
      pu_q      <= 1'b0;
      reject_q  <= 1'b0;
      pend      <= 1'b0;
      pend_j    <= 1'b0;
      btn_deb_q <= 1'b0;
    end else begin
      i_q       <= i_n;
      j_q       <= j_n;
      pu_q      <= pu_n;
      reject_q  <= reject_n;
      pend      <= pend_n;
      pend_j    <= pend_j_n;
      btn_deb_q <= btn_deb;
    end
  end

  assign bus.i      = i_q;
  assign bus.j      = j_q;
  assign bus.pu     = pu_q;
  assign bus.reject = reject_q;
  assign bus.jam    = (state == JAM);

endmodule

// File: tb/tb_coin_front_end.sv
// Randomised self-checking bench for coin_front_end with a width-range
// reference model and an event log of observed strobes.
module tb_coin_front_end;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int SMIN = 8;
  localparam int SMAX = 31;
  localparam int LMIN = 32;
  localparam int LMAX = 63;
  localparam int COIN_LAT = SYNC + 1;
  localparam int PU_LAT   = SYNC + DEB + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  coin_front_end_if bus();

  coin_front_end #(
    .SYNC_STAGES(SYNC),
    .DEB_CYCLES (DEB),
    .CNT_W      (8),
    .SMALL_MIN  (SMIN),
    .SMALL_MAX  (SMAX),
    .LARGE_MIN  (LMIN),
    .LARGE_MAX  (LMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    bit i;
    bit j;
    bit pu;
    bit reject;
  } ev_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  t       = 0;
  ev_t ev_q[$];
  bit  jam_hist[int];

  // Expected {i, j, reject} for a coin of w sensor-high cycles.
  function automatic logic [2:0] model_coin(input int w, input bit acc);
    if (w >= SMIN && w <= SMAX) return acc ? 3'b100 : 3'b001;
    if (w >= LMIN && w <= LMAX) return acc ? 3'b110 : 3'b001;
    return 3'b001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    jam_hist[t] = bus.jam;
    if (bus.i || bus.j || bus.pu || bus.reject)
      ev_q.push_back('{t, bus.i, bus.j, bus.pu, bus.reject});
  endtask

  task automatic drive_coin(input int w, input bit acc, output int tf);
    bus.accept_en = acc;
    bus.coin_sns  = 1'b1;
    repeat (w) tick();
    bus.coin_sns = 1'b0;
    tf = t;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    logic [4:0] got;
    repeat (3) tick();
    got = {bus.i, bus.j, bus.pu, bus.reject, bus.jam};
    n_tests++;
    if (got !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", got);
    end
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_coin();
    logic [4:0] got;
    int tf, dt, n;
    logic [2:0] ijr;
    ev_q.delete();
    bus.accept_en = 1'b1;
    bus.coin_sns  = 1'b1;
    repeat (20) tick();
    rst = 1'b0;
    bus.coin_sns = 1'b0;
    tick();
    got = {bus.i, bus.j, bus.pu, bus.reject, bus.jam};
    n_tests++;
    if (got !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_coin_outputs: got %b want 00000", got);
    end
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) tick();
    n_tests++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_coin_no_strobe: got %0d events want 0", ev_q.size());
    end
    ev_q.delete();
    drive_coin(20, 1'b1, tf);
    n = ev_q.size();
    dt = (n > 0) ? ev_q[0].t - tf : -1;
    ijr = (n > 0) ? {ev_q[0].i, ev_q[0].j, ev_q[0].reject} : 3'b000;
    n_tests++;
    if (n != 1 || dt != COIN_LAT || ijr !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_recover_coin: got n=%0d dt=%0d ijr=%b want n=1 dt=%0d ijr=100",
               n, dt, ijr, COIN_LAT);
    end
  endtask

  task automatic test_classify();
    int widths[10] = '{20, 45, 7, 8, 31, 32, 63, 3, 50, 12};
    int w, tf, dt, n;
    bit acc, pu_seen;
    logic [2:0] ijr, exp;
    for (int k = 0; k < 34; k++) begin
      if (k < 10) begin
        w   = widths[k];
        acc = 1'b1;
      end else begin
        w   = $urandom_range(3, 90);
        acc = 1'($urandom_range(0, 1));
      end
      ev_q.delete();
      drive_coin(w, acc, tf);
      repeat ($urandom_range(0, 4)) tick();
      exp = model_coin(w, acc);
      n   = ev_q.size();
      dt  = (n > 0) ? ev_q[0].t - tf : -1;
      ijr = (n > 0) ? {ev_q[0].i, ev_q[0].j, ev_q[0].reject} : 3'b000;
      pu_seen = (n > 0) ? ev_q[0].pu : 1'b0;
      n_tests++;
      if (n != 1 || dt != COIN_LAT || ijr !== exp || pu_seen) begin
        n_fail++;
        $display("FAIL classify_w%0d_acc%0d: got n=%0d dt=%0d ijr=%b pu=%0d want n=1 dt=%0d ijr=%b pu=0",
                 w, acc, n, dt, ijr, pu_seen, COIN_LAT, exp);
      end
    end
  endtask

  task automatic test_jam();
    int k0, tf, n, dt;
    logic [3:0] got_jam;
    logic [2:0] ijr;
    ev_q.delete();
    k0 = t;
    drive_coin(100, 1'b1, tf);
    got_jam = {jam_hist[k0 + COIN_LAT + LMAX - 1], jam_hist[k0 + COIN_LAT + LMAX],
               jam_hist[tf + COIN_LAT - 1], jam_hist[tf + COIN_LAT]};
    n_tests++;
    if (got_jam !== 4'b0110) begin
      n_fail++;
      $display("FAIL jam_level: got before/at64/beforeFall/afterFall=%b want 0110", got_jam);
    end
    n   = ev_q.size();
    dt  = (n > 0) ? ev_q[0].t - tf : -1;
    ijr = (n > 0) ? {ev_q[0].i, ev_q[0].j, ev_q[0].reject} : 3'b000;
    n_tests++;
    if (n != 1 || dt != COIN_LAT || ijr !== 3'b001) begin
      n_fail++;
      $display("FAIL jam_reject: got n=%0d dt=%0d ijr=%b want n=1 dt=%0d ijr=001",
               n, dt, ijr, COIN_LAT);
    end
  endtask

  task automatic test_accept_disable();
    int tf, n;
    logic [2:0] ijr;
    for (int k = 0; k < 2; k++) begin
      ev_q.delete();
      drive_coin((k == 0) ? 20 : 45, 1'b0, tf);
      n   = ev_q.size();
      ijr = (n > 0) ? {ev_q[0].i, ev_q[0].j, ev_q[0].reject} : 3'b000;
      n_tests++;
      if (n != 1 || ijr !== 3'b001 || ev_q[0].t != tf + COIN_LAT) begin
        n_fail++;
        $display("FAIL accept_disable_%0d: got n=%0d ijr=%b want n=1 ijr=001", k, n, ijr);
      end
    end
    bus.accept_en = 1'b1;
  endtask

  task automatic test_button();
    int npu, nother, tb0;
    ev_q.delete();
    for (int g = 0; g < 4; g++) begin
      bus.btn_raw = 1'b1;
      repeat ($urandom_range(1, DEB - 2)) tick();
      bus.btn_raw = 1'b0;
      repeat ($urandom_range(1, 5)) tick();
    end
    bus.btn_raw = 1'b1;
    repeat (40) tick();
    npu = 0; nother = 0;
    foreach (ev_q[e]) begin
      if (ev_q[e].pu) npu++;
      if (ev_q[e].i || ev_q[e].j || ev_q[e].reject) nother++;
    end
    n_tests++;
    if (npu != 1 || nother != 0) begin
      n_fail++;
      $display("FAIL button_press: got pu=%0d coin=%0d want pu=1 coin=0", npu, nother);
    end
    ev_q.delete();
    for (int g = 0; g < 4; g++) begin
      bus.btn_raw = 1'b0;
      repeat ($urandom_range(1, DEB - 2)) tick();
      bus.btn_raw = 1'b1;
      repeat ($urandom_range(1, 5)) tick();
    end
    bus.btn_raw = 1'b0;
    repeat (40) tick();
    n_tests++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL button_release: got %0d events want 0", ev_q.size());
    end
    ev_q.delete();
    tb0 = t;
    bus.btn_raw = 1'b1;
    repeat (30) tick();
    bus.btn_raw = 1'b0;
    repeat (40) tick();
    n_tests++;
    if (ev_q.size() != 1 || ev_q[0].t != tb0 + PU_LAT || !ev_q[0].pu) begin
      n_fail++;
      $display("FAIL button_latency: got n=%0d dt=%0d want n=1 dt=%0d",
               ev_q.size(), (ev_q.size() > 0) ? ev_q[0].t - tb0 : -1, PU_LAT);
    end
  endtask

  task automatic test_collision();
    int k0, n;
    logic [3:0] e0, e1;
    int t0, t1;
    ev_q.delete();
    bus.accept_en = 1'b1;
    k0 = t;
    bus.coin_sns = 1'b1;
    repeat (45 - DEB) tick();
    bus.btn_raw = 1'b1;
    repeat (DEB) tick();
    bus.coin_sns = 1'b0;
    repeat (10) tick();
    bus.btn_raw = 1'b0;
    repeat (40) tick();
    n  = ev_q.size();
    e0 = (n > 0) ? {ev_q[0].pu, ev_q[0].i, ev_q[0].j, ev_q[0].reject} : 4'b0;
    e1 = (n > 1) ? {ev_q[1].pu, ev_q[1].i, ev_q[1].j, ev_q[1].reject} : 4'b0;
    t0 = (n > 0) ? ev_q[0].t - k0 : -1;
    t1 = (n > 1) ? ev_q[1].t - k0 : -1;
    n_tests++;
    if (n != 2 || e0 !== 4'b1000 || t0 != 45 + COIN_LAT) begin
      n_fail++;
      $display("FAIL collision_pu: got n=%0d first puijr=%b at %0d want n=2 1000 at %0d",
               n, e0, t0, 45 + COIN_LAT);
    end
    n_tests++;
    if (e1 !== 4'b0110 || t1 != 46 + COIN_LAT) begin
      n_fail++;
      $display("FAIL collision_coin: got puijr=%b at %0d want 0110 at %0d",
               e1, t1, 46 + COIN_LAT);
    end
  endtask

  initial begin
    bus.coin_sns  = 1'b0;
    bus.btn_raw   = 1'b0;
    bus.accept_en = 1'b1;
    test_reset();
    test_reset_mid_coin();
    test_classify();
    test_jam();
    test_accept_disable();
    test_button();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
